// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive front end: FSM states, oversample
// constants and the baud divider computation.
// UART_RX_PARITY_EN adds the PARITY state (8E1 framing instead of 8N1).
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  // Clocks per oversample tick, never less than one.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    int unsigned d;
    d = clk_freq / (baud * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 0..DIV-1 counter producing the 16x oversample tick.
// clr_i restarts the count so a frame is timed from its start edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick on the last count value unless the counter is being restarted.
  always_comb begin
    tick_c = 1'b0;
    cnt_d  = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_W'(DIV - 1)) begin
      tick_c = 1'b1;
      cnt_d  = '0;
    end
    if (clr_i) begin
      tick_c = 1'b0;
      cnt_d  = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receiver: synchronizer, oversampled frame FSM, shift register and a
// one-entry holding register with valid/ready hand-off and error pulses.
// UART_RX_PARITY_EN selects 8E1 framing and enables parity_err_o.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 16_000_000,
  parameter int unsigned BAUD     = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int unsigned DIV    = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              rx_meta_q, rx_meta_d;
  logic              rx_sync_q, rx_sync_d;
  logic              rx_prev_q, rx_prev_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              parity_err_q, parity_err_d;
`endif

  logic baud_clr_c;
  logic baud_tick_c;
  logic byte_done_c;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .clr_i  (baud_clr_c),
    .tick_c (baud_tick_c)
  );

  // Next-state logic: synchronizer shift, frame FSM and holding register.
  always_comb begin
    rx_meta_d   = rx_i;
    rx_sync_d   = rx_meta_q;
    rx_prev_d   = rx_sync_q;
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    baud_clr_c  = 1'b0;
    byte_done_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    // Consumer hand-off; a same-cycle completion below re-asserts valid.
    if (valid_q && rx_ready_i) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Edge detection means a held-low line cannot re-arm the receiver.
        if (rx_prev_q && !rx_sync_q) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
          baud_clr_c = 1'b1;
        end
      end
      ST_START: begin
        if (baud_tick_c) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(MID_TICK - 1)) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_sync_q ? ST_IDLE : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (baud_tick_c) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            shift_d    = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick_c) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            par_d      = rx_sync_q;
            state_d    = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick_c) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            state_d    = ST_IDLE;
            if (!rx_sync_q) begin
              frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift_q, par_q}) begin
              parity_err_d = 1'b1;
`endif
            end else begin
              byte_done_c = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Holding register: drop the new byte if the old one is still unconsumed.
    if (byte_done_c) begin
      if (valid_q && !rx_ready_i) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at 16 clocks per bit.
// Honors UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_frontend;

`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b1;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  int n_chk = 0;
  int n_err = 0;

  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cyc = 0;
  int         n_vrise = 0;
  int         n_vcyc = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         n_perr = 0;
  int         total_perr = 0;
  logic [7:0] last_data = 8'h00;
  logic       v_prev = 1'b0;

  uart_rx_frontend #(
    .CLK_FREQ (16_000_000),
    .BAUD     (1_000_000)
  ) dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o)
  );

  always #5 clk = ~clk;

  // Event monitor sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (rx_valid_o === 1'b1) begin
      n_vcyc++;
      if (!v_prev) begin
        n_vrise++;
        last_data = rx_data_o;
        rise_cyc  = cyc;
      end
    end
    v_prev = (rx_valid_o === 1'b1);
    if (frame_err_o === 1'b1) n_ferr++;
    if (overrun_o === 1'b1) n_ovr++;
    if (parity_err_o === 1'b1) begin
      n_perr++;
      total_perr++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_vrise = 0;
    n_vcyc  = 0;
    n_ferr  = 0;
    n_ovr   = 0;
    n_perr  = 0;
  endtask

  task automatic send_bit(input logic v);
    rx_i = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Full frame with correct parity (when enabled) and a chosen stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop);
    idle(24);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_data", rx_data_o, 8'h00);
    check_eq("rst_valid", rx_valid_o, 1'b0);
    check_eq("rst_ferr", frame_err_o, 1'b0);
    check_eq("rst_ovr", overrun_o, 1'b0);
    check_eq("rst_perr", parity_err_o, 1'b0);
    rst_n = 1'b1;
    idle(20);

    // A5 with ready held high
    clear_mon();
    send_frame(8'hA5, 1'b1);
    check_eq("a5_rise", n_vrise, 1);
    check_eq("a5_data", last_data, 8'hA5);
    check_eq("a5_latency", rise_cyc - start_cyc, LAT);
    check_eq("a5_valid_cycles", n_vcyc, 1);
    check_eq("a5_ferr", n_ferr, 0);
    check_eq("a5_ovr", n_ovr, 0);

    // False start: 5-clock glitch
    clear_mon();
    rx_i = 1'b0;
    repeat (5) @(negedge clk);
    idle(60);
    check_eq("glitch_valid", n_vrise, 0);
    check_eq("glitch_ferr", n_ferr, 0);
    check_eq("glitch_perr", n_perr, 0);

    // Stop bit low
    clear_mon();
    send_frame(8'h3C, 1'b0);
    check_eq("3c_ferr", n_ferr, 1);
    check_eq("3c_valid", n_vrise, 0);

    // Overrun: second byte dropped while first is unconsumed
    clear_mon();
    rx_ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check_eq("ovr_data", rx_data_o, 8'h11);
    check_eq("ovr_valid", rx_valid_o, 1'b1);
    check_eq("ovr_pulses", n_ovr, 1);
    check_eq("ovr_rise", n_vrise, 1);
    rx_ready_i = 1'b1;
    @(negedge clk);
    check_eq("ovr_drain", rx_valid_o, 1'b0);

    // Completion in the same cycle as ready: new byte replaces old
    rx_ready_i = 1'b0;
    send_frame(8'h33, 1'b1);
    clear_mon();
    fork
      send_frame(8'h44, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        check_eq("same_pre_data", rx_data_o, 8'h33);
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
        check_eq("same_data", rx_data_o, 8'h44);
        check_eq("same_valid", rx_valid_o, 1'b1);
      end
    join
    check_eq("same_ovr", n_ovr, 0);
    check_eq("same_hold", rx_data_o, 8'h44);
    rx_ready_i = 1'b1;
    @(negedge clk);
    check_eq("same_drain", rx_valid_o, 1'b0);

    // Reset during data bit 3 of FF, then 5A
    clear_mon();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_data", rx_data_o, 8'h00);
        check_eq("midrst_valid", rx_valid_o, 1'b0);
        rst_n = 1'b1;
      end
    join
    check_eq("midrst_no_ff", n_vrise, 0);
    send_frame(8'h5A, 1'b1);
    check_eq("midrst_5a_rise", n_vrise, 1);
    check_eq("midrst_5a_data", last_data, 8'h5A);

    // Break: one frame error, no re-arm until the line returns high
    clear_mon();
    rx_i = 1'b0;
    repeat (400) @(negedge clk);
    idle(40);
    check_eq("break_ferr", n_ferr, 1);
    check_eq("break_valid", n_vrise, 0);
    send_frame(8'h96, 1'b1);
    check_eq("break_rearm", last_data, 8'h96);
    check_eq("break_rise", n_vrise, 1);

`ifdef UART_RX_PARITY_EN
    // 07 with wrong then right parity bit
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit((i < 3) ? 1'b1 : 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    idle(24);
    check_eq("par_bad_perr", n_perr, 1);
    check_eq("par_bad_valid", n_vrise, 0);
    check_eq("par_bad_ferr", n_ferr, 0);
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit((i < 3) ? 1'b1 : 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    idle(24);
    check_eq("par_ok_perr", n_perr, 0);
    check_eq("par_ok_rise", n_vrise, 1);
    check_eq("par_ok_data", last_data, 8'h07);
`else
    check_eq("no_par_pulses", total_perr, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
